dvi_rx_symbol_align: RTL and testbench



---
 rtl/dvi_rx_symbol_align.sv | 143 ++++++++++++++
 tb/tb_dvi_rx_symbol_align.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_rx_symbol_align.sv
// TMDS lane word aligner: hunts control-token runs during blanking
// to find the symbol boundary, then emits aligned symbols with lock.
module dvi_rx_symbol_align #(
  parameter int MIN_CTRL_RUN   = 8,
  parameter int LOCK_COUNT     = 4,
  parameter int SEARCH_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  output logic [9:0] dout,
  output logic       dout_valid,
  output logic       locked,
  output logic [3:0] offset,
  output logic       slip
);

  localparam int RW = $clog2(MIN_CTRL_RUN + 1);
  localparam int TW = $clog2(SEARCH_TIMEOUT);
  localparam int GW = $clog2(LOCK_COUNT + 1);

  localparam logic [9:0] CTRL0 = 10'b1101010100;
  localparam logic [9:0] CTRL1 = 10'b0010101011;
  localparam logic [9:0] CTRL2 = 10'b0101010100;
  localparam logic [9:0] CTRL3 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH,
    SETTLE,
    LOCKED
  } state_e;

  state_e        state_q, state_d;
  logic [9:0]    prev_q;
  logic [9:0]    dout_q;
  logic [3:0]    offset_q, offset_d;
  logic          slip_q, slip_d;
  logic [RW-1:0] run_q, run_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] good_q, good_d;
  logic          settle_q, settle_d;

  logic [19:0]   window;
  logic [9:0]    aligned;
  logic          is_ctrl;
  logic          qual;
  logic          expiry;

  assign window  = {din, prev_q};
  assign aligned = window[offset_q +: 10];

  assign is_ctrl = (aligned == CTRL0) || (aligned == CTRL1) ||
                   (aligned == CTRL2) || (aligned == CTRL3);

  // Fires only on the step to the threshold, so a long run counts once
  assign qual   = is_ctrl && (run_q == RW'(MIN_CTRL_RUN - 1));
  assign expiry = (tmo_q == TW'(SEARCH_TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    slip_d   = 1'b0;
    good_d   = good_q;
    settle_d = settle_q;
    tmo_d    = qual ? '0 : tmo_q + TW'(1);
    if (!is_ctrl) begin
      run_d = '0;
    end else if (run_q == RW'(MIN_CTRL_RUN)) begin
      run_d = run_q;
    end else begin
      run_d = run_q + RW'(1);
    end
    unique case (state_q)
      SEARCH: begin
        if (qual) begin
          good_d = good_q + GW'(1);
          if (good_q == GW'(LOCK_COUNT - 1)) begin
            state_d = LOCKED;
          end
        end else if (expiry) begin
          offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
          slip_d   = 1'b1;
          run_d    = '0;
          tmo_d    = '0;
          good_d   = '0;
          settle_d = 1'b0;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        // Timeout stays parked so the next search window is full length
        run_d    = '0;
        tmo_d    = '0;
        settle_d = 1'b1;
        if (settle_q) begin
          state_d = SEARCH;
        end
      end
      LOCKED: begin
        if (!qual && expiry) begin
          state_d = SEARCH;
          good_d  = '0;
          run_d   = '0;
          tmo_d   = '0;
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEARCH;
      prev_q   <= '0;
      dout_q   <= '0;
      offset_q <= '0;
      slip_q   <= 1'b0;
      run_q    <= '0;
      tmo_q    <= '0;
      good_q   <= '0;
      settle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= din;
      dout_q   <= aligned;
      offset_q <= offset_d;
      slip_q   <= slip_d;
      run_q    <= run_d;
      tmo_q    <= tmo_d;
      good_q   <= good_d;
      settle_q <= settle_d;
    end
  end

  assign dout       = dout_q;
  assign locked     = (state_q == LOCKED);
  assign dout_valid = (state_q == LOCKED);
  assign offset     = offset_q;
  assign slip       = slip_q;

endmodule

// File: tb/tb_dvi_rx_symbol_align.sv
// Directed bench for dvi_rx_symbol_align: slip timing, lock,
// loss of lock, simultaneous run/expiry and reset in each state.
module tb_dvi_rx_symbol_align;

  localparam logic [9:0] CTRL = 10'b1101010100;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] din;
  logic [9:0] dout;
  logic       dout_valid;
  logic       locked;
  logic [3:0] offset;
  logic       slip;

  int checks = 0;
  int fails  = 0;
  int t      = 0;
  int cur    = 0;
  int phase  = 3;
  int mode   = 0;
  int clen   = 16;
  int dead_from = 32'h3fff_ffff;
  int win[$];

  dvi_rx_symbol_align #(
    .MIN_CTRL_RUN  (8),
    .LOCK_COUNT    (4),
    .SEARCH_TIMEOUT(128)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .dout      (dout),
    .dout_valid(dout_valid),
    .locked    (locked),
    .offset    (offset),
    .slip      (slip)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] data_sym(int k);
    logic [31:0] kk;
    kk = k;
    return {5'b11111, kk[4:0]};
  endfunction

  function automatic logic [9:0] sym(int k);
    if (mode == 0) begin
      if (k < dead_from && (k % (64 + clen)) >= 64) return CTRL;
    end else begin
      foreach (win[i]) begin
        if (k >= win[i] && k < win[i] + 8) return CTRL;
      end
    end
    return data_sym(k);
  endfunction

  function automatic logic [9:0] word(int k);
    logic [19:0] pr;
    pr = {sym(k + 1), sym(k)};
    return pr[((10 - phase) % 10) +: 10];
  endfunction

  task automatic step();
    din = word(t);
    @(posedge clk);
    #1;
    cur = t;
    t = t + 1;
  endtask

  task automatic apply_reset(int n);
    rst = 1'b1;
    din = 10'h155;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    t = 0;
  endtask

  task automatic run_lock_check(int last);
    logic       e_slip;
    logic [3:0] e_off;
    logic       e_lock;
    while (t <= last) begin
      step();
      e_slip = (cur == 127 || cur == 257 || cur == 387);
      e_off  = (cur < 127) ? 4'd0 : (cur < 257) ? 4'd1 :
               (cur < 387) ? 4'd2 : 4'd3;
      e_lock = (cur >= 631);
      checks++;
      if (slip !== e_slip) begin
        fails++;
        $display("FAIL lock_slip t=%0d got=%b exp=%b", cur, slip, e_slip);
      end
      checks++;
      if (offset !== e_off) begin
        fails++;
        $display("FAIL lock_offset t=%0d got=%0d exp=%0d", cur, offset, e_off);
      end
      checks++;
      if (locked !== e_lock) begin
        fails++;
        $display("FAIL lock_locked t=%0d got=%b exp=%b", cur, locked, e_lock);
      end
      checks++;
      if (dout_valid !== e_lock) begin
        fails++;
        $display("FAIL lock_valid t=%0d got=%b exp=%b", cur, dout_valid, e_lock);
      end
      if (cur >= 388) begin
        checks++;
        if (dout !== sym(cur)) begin
          fails++;
          $display("FAIL lock_dout t=%0d got=%h exp=%h", cur, dout, sym(cur));
        end
      end
    end
  endtask

  task automatic test_reset();
    mode = 0; clen = 16; phase = 3; dead_from = 32'h3fff_ffff;
    rst = 1'b1;
    din = 10'h155;
    @(posedge clk);
    #1;
    checks++;
    if ({dout, dout_valid, locked, offset, slip} !== 17'd0) begin
      fails++;
      $display("FAIL por_outputs got=%h exp=0",
               {dout, dout_valid, locked, offset, slip});
    end
    rst = 1'b0;
    t = 0;
    repeat (140) step();
    checks++;
    if (offset !== 4'd1) begin
      fails++;
      $display("FAIL pre_reset_offset got=%0d exp=1", offset);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (dout !== 10'd0) begin
      fails++;
      $display("FAIL rst_dout got=%h exp=0", dout);
    end
    checks++;
    if (locked !== 1'b0 || dout_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_lock got=%b%b exp=00", locked, dout_valid);
    end
    checks++;
    if (offset !== 4'd0) begin
      fails++;
      $display("FAIL rst_offset got=%0d exp=0", offset);
    end
    checks++;
    if (slip !== 1'b0) begin
      fails++;
      $display("FAIL rst_slip got=%b exp=0", slip);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (offset !== 4'd0 || locked !== 1'b0) begin
      fails++;
      $display("FAIL rst_hold got=%0d/%b exp=0/0", offset, locked);
    end
    rst = 1'b0;
    t = 0;
  endtask

  task automatic test_lock();
    mode = 0; clen = 16; phase = 3; dead_from = 32'h3fff_ffff;
    apply_reset(2);
    run_lock_check(699);
  endtask

  task automatic test_data_loss();
    logic e_lock;
    dead_from = 704;
    while (t <= 779) begin
      step();
      e_lock = (cur < 759);
      checks++;
      if (locked !== e_lock || dout_valid !== e_lock) begin
        fails++;
        $display("FAIL loss_locked t=%0d got=%b/%b exp=%b",
                 cur, locked, dout_valid, e_lock);
      end
      checks++;
      if (slip !== 1'b0) begin
        fails++;
        $display("FAIL loss_slip t=%0d got=%b exp=0", cur, slip);
      end
      checks++;
      if (offset !== 4'd3) begin
        fails++;
        $display("FAIL loss_offset t=%0d got=%0d exp=3", cur, offset);
      end
    end
  endtask

  task automatic test_short_runs();
    int         n;
    logic       e_slip;
    logic [3:0] e_off;
    mode = 0; clen = 7; phase = 3; dead_from = 32'h3fff_ffff;
    apply_reset(2);
    while (t <= 1309) begin
      step();
      n = (cur >= 127) ? ((cur - 127) / 130 + 1) : 0;
      e_slip = (cur >= 127) && (((cur - 127) % 130) == 0);
      e_off = 4'(n % 10);
      checks++;
      if (slip !== e_slip) begin
        fails++;
        $display("FAIL short_slip t=%0d got=%b exp=%b", cur, slip, e_slip);
      end
      checks++;
      if (offset !== e_off) begin
        fails++;
        $display("FAIL short_offset t=%0d got=%0d exp=%0d", cur, offset, e_off);
      end
      checks++;
      if (locked !== 1'b0) begin
        fails++;
        $display("FAIL short_locked t=%0d got=%b exp=0", cur, locked);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic e_lock;
    mode = 1; phase = 0;
    win = '{119, 200, 280, 360, 488};
    apply_reset(2);
    while (t <= 639) begin
      step();
      e_lock = (cur >= 368) && (cur < 624);
      checks++;
      if (slip !== 1'b0) begin
        fails++;
        $display("FAIL simul_slip t=%0d got=%b exp=0", cur, slip);
      end
      checks++;
      if (offset !== 4'd0) begin
        fails++;
        $display("FAIL simul_offset t=%0d got=%0d exp=0", cur, offset);
      end
      checks++;
      if (locked !== e_lock) begin
        fails++;
        $display("FAIL simul_locked t=%0d got=%b exp=%b", cur, locked, e_lock);
      end
    end
  endtask

  task automatic test_back_to_back();
    mode = 0; clen = 16; phase = 3; dead_from = 32'h3fff_ffff;
    apply_reset(2);
    run_lock_check(640);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({dout, dout_valid, locked, offset, slip} !== 17'd0) begin
      fails++;
      $display("FAIL rst_locked got=%h exp=0",
               {dout, dout_valid, locked, offset, slip});
    end
    rst = 1'b0;
    t = 0;
    while (t <= 127) step();
    checks++;
    if (slip !== 1'b1 || offset !== 4'd1) begin
      fails++;
      $display("FAIL pre_settle got=%b/%0d exp=1/1", slip, offset);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({dout, dout_valid, locked, offset, slip} !== 17'd0) begin
      fails++;
      $display("FAIL rst_settle got=%h exp=0",
               {dout, dout_valid, locked, offset, slip});
    end
    rst = 1'b0;
    t = 0;
    run_lock_check(699);
  endtask

  initial begin
    rst = 1'b1;
    din = '0;
    test_reset();
    test_lock();
    test_data_loss();
    test_short_runs();
    test_simultaneous();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
